// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the E stage: ALU ops, mult/div ops, write-data select.
package execute_muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,   // b << a[4:0]
    ALU_SRL  = 4'd9,   // b >> a[4:0]
    ALU_SRA  = 4'd10,  // b >>> a[4:0]
    ALU_LUI  = 4'd11   // b << 16
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    WD_E   = 2'b00,
    WD_ALU = 2'b01,
    WD_HI  = 2'b10,
    WD_LO  = 2'b11
  } wd_sel_e;

endpackage

// File: rtl/execute_muldiv_if.sv
// E-stage bus: decoded controls/operands in, write data, store data and busy out.
interface execute_muldiv_if #(parameter int WIDTH = 32);
  import execute_muldiv_pkg::*;

  logic             valid_e;
  alu_op_e          alu_op;
  logic             alu_a_sel;
  logic             alu_b_sel;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] imm32;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] wd_e;
  wd_sel_e          wd_sel;
  md_op_e           md_op;
  logic [WIDTH-1:0] wd_em;
  logic [WIDTH-1:0] rd2_em;
  logic             md_busy;

  modport master (
    output valid_e, alu_op, alu_a_sel, alu_b_sel, shamt, imm32,
           fwd_a, fwd_b, wd_e, wd_sel, md_op,
    input  wd_em, rd2_em, md_busy
  );

  modport slave (
    input  valid_e, alu_op, alu_a_sel, alu_b_sel, shamt, imm32,
           fwd_a, fwd_b, wd_e, wd_sel, md_op,
    output wd_em, rd2_em, md_busy
  );
endinterface

// File: rtl/execute_muldiv_muldiv_unit.sv
// Multi-cycle mult/div unit: result computed at start, held in pend regs,
// committed to HI/LO on the last busy edge.
module execute_muldiv_muldiv_unit
  import execute_muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  md_op_e           md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_busy
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]    MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [2*WIDTH-1:0] res;
  logic               busy, start;

  assign busy    = (cnt_q != '0);
  assign start   = valid && (md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !busy;
  assign md_busy = start | busy;
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Full {HI,LO} result of the requested op; div corner cases pinned explicitly.
  always_comb begin
    res = '0;
    case (md_op)
      MD_MULT:  res = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      MD_MULTU: res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      MD_DIV: begin
        if (b == '0)                      res = {a, ONES};
        else if (a == SMIN && b == ONES)  res = {{WIDTH{1'b0}}, SMIN};
        else                              res = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      end
      MD_DIVU: begin
        if (b == '0) res = {a, ONES};
        else         res = {a % b, a / b};
      end
      default:  res = '0;
    endcase
  end

  // Next state: count down while busy (commit on last edge), else start or mthi/mtlo.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start) begin
      cnt_d = (md_op inside {MD_MULT, MD_MULTU}) ? MULT_CNT : DIV_CNT;
      {pend_hi_d, pend_lo_d} = res;
    end else if (valid && md_op == MD_MTHI) begin
      hi_d = a;
    end else if (valid && md_op == MD_MTLO) begin
      lo_d = a;
    end
  end

  // State registers, cleared by async reset even mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end
endmodule

// File: rtl/execute_muldiv.sv
// MIPS E stage: ALU operand muxes, ALU, mult/div unit and write-data mux to M.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  execute_muldiv_if.slave bus
);
  logic [WIDTH-1:0] alu_a, alu_b, alu_y, hi, lo;

  assign alu_a = bus.alu_a_sel ? WIDTH'(bus.shamt) : bus.fwd_a;
  assign alu_b = bus.alu_b_sel ? bus.imm32 : bus.fwd_b;

  // ALU: shifts move operand b by a[4:0] so sll/srl take shamt via alu_a_sel.
  always_comb begin
    alu_y = '0;
    case (bus.alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_NOR:  alu_y = ~(alu_a | alu_b);
      ALU_SLT:  alu_y = WIDTH'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_y = WIDTH'(alu_a < alu_b);
      ALU_SLL:  alu_y = alu_b << alu_a[4:0];
      ALU_SRL:  alu_y = alu_b >> alu_a[4:0];
      ALU_SRA:  alu_y = $signed(alu_b) >>> alu_a[4:0];
      ALU_LUI:  alu_y = alu_b << 16;
      default:  alu_y = '0;
    endcase
  end

  execute_muldiv_muldiv_unit #(
    .WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) u_md (
    .clk(clk), .rst(reset), .valid(bus.valid_e), .md_op(bus.md_op),
    .a(bus.fwd_a), .b(bus.fwd_b), .hi(hi), .lo(lo), .md_busy(bus.md_busy)
  );

  // Write-data select toward M; HI/LO reads always return the committed value.
  always_comb begin
    case (bus.wd_sel)
      WD_E:    bus.wd_em = bus.wd_e;
      WD_ALU:  bus.wd_em = alu_y;
      WD_HI:   bus.wd_em = hi;
      default: bus.wd_em = lo;
    endcase
  end

  assign bus.rd2_em = bus.fwd_b;
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed cases with literal results plus random
// traffic checked every cycle against a cycle-stamp model of HI/LO.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  execute_muldiv_if #(.WIDTH(W)) bus();
  execute_muldiv #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: committed HI/LO, a pending result and the cycle it becomes visible.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend;
  int          cyc, fin_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] md_ref(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    p = '0;
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          ua = (sa < 0) ? -sa : sa;
          ub = (sb < 0) ? -sb : sb;
          q  = ua / ub;
          r  = ua % ub;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          p = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] alu_ref(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'({32'b0, a}) < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      ALU_LUI:  return {b[15:0], 16'h0};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic bit is_md(input md_op_e op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pend = 0;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_model();
    logic [31:0] a, b, exp_wd;
    a = bus.alu_a_sel ? {27'b0, bus.shamt} : bus.fwd_a;
    b = bus.alu_b_sel ? bus.imm32 : bus.fwd_b;
    case (bus.wd_sel)
      WD_E:    exp_wd = bus.wd_e;
      WD_ALU:  exp_wd = alu_ref(bus.alu_op, a, b);
      WD_HI:   exp_wd = m_hi;
      default: exp_wd = m_lo;
    endcase
    chk("md_busy", 32'(bus.md_busy), 32'(m_pend || (bus.valid_e && is_md(bus.md_op))));
    chk("rd2_em", bus.rd2_em, bus.fwd_b);
    chk("wd_em", bus.wd_em, exp_wd);
  endtask

  // Clock-edge effect of the current inputs on the model.
  task automatic model_update();
    if (!reset && !m_pend && bus.valid_e) begin
      if (is_md(bus.md_op)) begin
        {m_phi, m_plo} = md_ref(bus.md_op, bus.fwd_a, bus.fwd_b);
        m_pend  = 1;
        fin_cyc = cyc + 1 + ((bus.md_op == MD_MULT || bus.md_op == MD_MULTU) ? MC : DC);
      end else if (bus.md_op == MD_MTHI) m_hi = bus.fwd_a;
      else if (bus.md_op == MD_MTLO)     m_lo = bus.fwd_a;
    end
    cyc++;
    if (m_pend && cyc == fin_cyc) begin
      m_hi = m_phi; m_lo = m_plo; m_pend = 0;
    end
  endtask

  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.valid_e = 1'b1; bus.alu_op = ALU_ADD; bus.alu_a_sel = 1'b0; bus.alu_b_sel = 1'b0;
    bus.shamt = '0; bus.imm32 = '0; bus.fwd_a = '0; bus.fwd_b = '0; bus.wd_e = '0;
    bus.wd_sel = WD_E; bus.md_op = MD_NONE;
  endtask

  // Issue one md op and count md_busy cycles; optionally try mtlo while busy.
  task automatic run_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int nbusy);
    bus.valid_e = 1'b1; bus.md_op = op; bus.fwd_a = a; bus.fwd_b = b; bus.wd_sel = WD_E;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.md_busy) break;
      nbusy++;
      step();
      bus.md_op = (inject && i == 0) ? MD_MTLO : MD_NONE;
      if (inject && i == 0) bus.fwd_a = 32'h1234;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.md_op = MD_NONE; bus.wd_sel = WD_HI;
    #1 hi = bus.wd_em;
    step();
    bus.wd_sel = WD_LO;
    #1 lo = bus.wd_em;
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic [31:0] hi, lo;

    drive_idle();
    model_clear();
    cyc = 0;
    repeat (2) @(negedge clk);

    // reset state
    bus.wd_sel = WD_HI;
    #1;
    chk("reset md_busy", 32'(bus.md_busy), 32'd0);
    chk("reset HI", bus.wd_em, 32'd0);
    step();
    bus.wd_sel = WD_LO;
    #1 chk("reset LO", bus.wd_em, 32'd0);
    step();
    reset = 1'b0;

    // signed mult: -1 * 2
    run_md(MD_MULT, 32'hFFFF_FFFF, 32'd2, 0, nb);
    chk("mult busy cycles", 32'(nb), 32'd6);
    read_hilo(hi, lo);
    chk("mult HI", hi, 32'hFFFF_FFFF);
    chk("mult LO", lo, 32'hFFFF_FFFE);

    // unsigned mult, same operands
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, nb);
    read_hilo(hi, lo);
    chk("multu HI", hi, 32'h0000_0001);
    chk("multu LO", lo, 32'hFFFF_FFFE);

    // signed div, negative dividend, and MIN / -1 overflow
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, nb);
    chk("div busy cycles", 32'(nb), 32'd11);
    read_hilo(hi, lo);
    chk("div LO", lo, 32'hFFFF_FFFD);
    chk("div HI", hi, 32'hFFFF_FFFF);
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, nb);
    read_hilo(hi, lo);
    chk("div ovf LO", lo, 32'h8000_0000);
    chk("div ovf HI", hi, 32'h0);

    // divu by zero, with an illegal mtlo while busy
    run_md(MD_DIVU, 32'd7, 32'd0, 1, nb);
    chk("divu0 busy no restart", 32'(nb), 32'd11);
    read_hilo(hi, lo);
    chk("divu0 HI", hi, 32'h0000_0007);
    chk("divu0 LO", lo, 32'hFFFF_FFFF);

    // mthi then mfhi next cycle
    bus.md_op = MD_MTHI; bus.fwd_a = 32'hABCD; bus.wd_sel = WD_E;
    step();
    bus.md_op = MD_NONE; bus.wd_sel = WD_HI;
    #1 chk("mthi->mfhi", bus.wd_em, 32'h0000_ABCD);
    step();

    // bubble carrying a mult must not start
    bus.valid_e = 1'b0; bus.md_op = MD_MULT;
    #1 chk("bubble md_busy", 32'(bus.md_busy), 32'd0);
    step();
    bus.valid_e = 1'b1; bus.md_op = MD_NONE;
    #1 chk("bubble no latent busy", 32'(bus.md_busy), 32'd0);
    step();

    // async reset in the middle of a div (cnt = 3)
    bus.md_op = MD_DIV; bus.fwd_a = 32'd100; bus.fwd_b = 32'd7;
    step();
    bus.md_op = MD_NONE;
    repeat (7) step();
    #1;
    reset = 1'b1;
    model_clear();
    bus.wd_sel = WD_HI;
    #1;
    chk("midop reset md_busy", 32'(bus.md_busy), 32'd0);
    chk("midop reset HI", bus.wd_em, 32'd0);
    step();
    bus.wd_sel = WD_LO;
    #1 chk("midop reset LO", bus.wd_em, 32'd0);
    step();
    reset = 1'b0;

    // ALU add, register and immediate operand
    bus.wd_sel = WD_ALU; bus.alu_op = ALU_ADD; bus.fwd_a = 32'd3; bus.fwd_b = 32'd4;
    #1 chk("alu add", bus.wd_em, 32'd7);
    step();
    bus.alu_b_sel = 1'b1; bus.imm32 = 32'd4; bus.fwd_b = 32'd0;
    #1 chk("alu addi", bus.wd_em, 32'd7);
    step();

    // random traffic including hazard violations and occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (reset) model_clear();
      bus.valid_e   = ($urandom_range(0, 7) != 0);
      bus.md_op     = ($urandom_range(0, 9) < 6) ? MD_NONE : md_op_e'(3'($urandom_range(1, 6)));
      bus.wd_sel    = wd_sel_e'(2'($urandom_range(0, 3)));
      bus.alu_op    = alu_op_e'(4'($urandom_range(0, 15)));
      bus.alu_a_sel = 1'($urandom_range(0, 1));
      bus.alu_b_sel = 1'($urandom_range(0, 1));
      bus.shamt     = 5'($urandom);
      bus.imm32     = pick();
      bus.fwd_a     = pick();
      bus.fwd_b     = pick();
      bus.wd_e      = $urandom;
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
